// File: rtl/i2c_slave_regs.sv
// I2C target with a 256-byte register window behind a simple synchronous
// register port. The first written byte sets the pointer, later bytes write
// registers, and reads stream from the pointer. SCL is never stretched.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | bus free, SDA released, waiting for START
// ST_ADDR     | shifting in the address byte
// ST_ADDR_ACK | driving ACK for our address
// ST_WR_BYTE  | shifting in a pointer/data byte from the master
// ST_WR_ACK   | driving ACK for a received byte
// ST_RD_BYTE  | driving a register byte MSB first
// ST_RD_ACK   | released, sampling the master's ACK/NACK
// ST_IGNORE   | not addressed or read finished; wait for START/STOP
`timescale 1ns/1ps
module i2c_slave_regs #(
    parameter logic [6:0] I2C_ADDRESS = 7'h2D,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i2c_scl_in,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_drive_n,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       stop_seen
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_BYTE,
        ST_WR_ACK,
        ST_RD_BYTE,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       first_byte_q, first_byte_d;
    logic       ack_q, ack_d;
    logic       sda_n_q, sda_n_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       we_q, we_d;
    logic       rd_q, rd_d;
    logic       busy_q, busy_d;
    logic       stop_q, stop_d;
    logic       inc_q, inc_d;

    // Synchronize the bus lines; idle bus level is high, so reset to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i2c_scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i2c_sda_in};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev;
    assign scl_fall  = ~scl_s & scl_prev;
    assign start_det = scl_s & sda_prev & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev & sda_s;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'h00;
            rw_q         <= 1'b0;
            first_byte_q <= 1'b0;
            ack_q        <= 1'b0;
            sda_n_q      <= 1'b1;
            addr_q       <= 8'h00;
            wdata_q      <= 8'h00;
            we_q         <= 1'b0;
            rd_q         <= 1'b0;
            busy_q       <= 1'b0;
            stop_q       <= 1'b0;
            inc_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rw_q         <= rw_d;
            first_byte_q <= first_byte_d;
            ack_q        <= ack_d;
            sda_n_q      <= sda_n_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            stop_q       <= stop_d;
            inc_q        <= inc_d;
        end
    end

    // Next-state logic; START/STOP take priority over every state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        rw_d         = rw_q;
        first_byte_d = first_byte_q;
        ack_d        = ack_q;
        sda_n_d      = sda_n_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        rd_d         = 1'b0;
        busy_d       = busy_q;
        stop_d       = 1'b0;
        inc_d        = 1'b0;

        // Pointer advances the cycle after a register write strobe.
        if (inc_q) begin
            addr_d = addr_q + 8'd1;
        end

        if (stop_det) begin
            state_d = ST_IDLE;
            sda_n_d = 1'b1;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_n_d   = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (shift_q[7:1] == I2C_ADDRESS) begin
                            sda_n_d      = 1'b0;
                            state_d      = ST_ADDR_ACK;
                            busy_d       = 1'b1;
                            rw_d         = shift_q[0];
                            first_byte_d = 1'b0;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_rise && rw_q) begin
                        rd_d = 1'b1;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            shift_d = reg_rdata;
                            sda_n_d = reg_rdata[7];
                            state_d = ST_RD_BYTE;
                        end else begin
                            sda_n_d = 1'b1;
                            state_d = ST_WR_BYTE;
                        end
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_n_d = 1'b0;
                        state_d = ST_WR_ACK;
                        if (!first_byte_q) begin
                            addr_d       = shift_q;
                            first_byte_d = 1'b1;
                        end else begin
                            wdata_d = shift_q;
                            we_d    = 1'b1;
                            inc_d   = 1'b1;
                        end
                    end
                end
                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_n_d   = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_n_d = 1'b1;
                            addr_d  = addr_q + 8'd1;
                            ack_d   = 1'b0;
                            state_d = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_n_d   = shift_q[6];
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            rd_d  = 1'b1;
                            ack_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && ack_q) begin
                        shift_d   = reg_rdata;
                        sda_n_d   = reg_rdata[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RD_BYTE;
                    end
                end
                default: begin
                    sda_n_d = 1'b1;
                end
            endcase
        end
    end

    assign i2c_sda_drive_n = sda_n_q;
    assign reg_addr        = addr_q;
    assign reg_wdata       = wdata_q;
    assign reg_we          = we_q;
    assign reg_rd          = rd_q;
    assign busy            = busy_q;
    assign stop_seen       = stop_q;

endmodule
